// File: rtl/dds_pkg.sv
// ----------------------------------------------------------------------------
// dds_pkg
//   Shared definitions for the DDS frequency-sweep scheduler: default widths,
//   sweep mode / FSM state encodings and sweep direction constants.
// ----------------------------------------------------------------------------
package dds_pkg;

    localparam int DDS_FCW_W   = 64;  // frequency control word width
    localparam int DDS_DWELL_W = 24;  // dwell counter width (clk cycles per point)

    // cfg_mode encoding; the fourth code (2'd3) is reserved and behaves as single.
    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_REPEAT = 2'd1,
        MODE_TRI    = 2'd2
    } sweep_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } sweep_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : dds_pkg

// File: rtl/dds_dwell_timer.sv
// ----------------------------------------------------------------------------
// dds_dwell_timer
//   Down-counter that times how long one sweep point is held.
//   Ports:
//     clk       system clock
//     rst       synchronous reset, active-high
//     load_i    (re)load the counter with dwell_i for a new point
//     en_i      count while a sweep is active
//     dwell_i   cycles per point; 0 is treated as 1
//     expire_o  high during the last cycle of the current point
// ----------------------------------------------------------------------------
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int DWELL_W = DDS_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               en_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               expire_o
);

    logic [DWELL_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
        end else if (en_i && count_q != '0) begin
            count_d = count_q - DWELL_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    // The count was loaded with the dwell on the cycle the point first appears,
    // so reaching 1 marks the final cycle of that point.
    assign expire_o = en_i && (count_q == DWELL_W'(1));

endmodule : dds_dwell_timer

// File: rtl/dds_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// dds_sweep_ctrl
//   Frequency-sweep scheduler for the DDS carrier path. Steps a frequency
//   control word from start to stop in fixed increments, holding each point
//   for a programmable number of cycles (single, sawtooth-repeat or triangle).
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     cfg_valid / cfg_ready     config write handshake (ready only in IDLE)
//     cfg_start/stop/step       sweep limits and increment (FCW units)
//     cfg_dwell                 cycles per point (0 behaves as 1)
//     cfg_mode                  0 single, 1 repeat, 2 triangle, 3 as single
//     go / abort                start (IDLE only) / stop at once
//     fcw_out / fcw_upd         current FCW and its change strobe
//     busy / done / cfg_err     activity, end-of-single pulse, sticky config error
// ----------------------------------------------------------------------------
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FCW_W   = DDS_FCW_W,
    parameter int DWELL_W = DDS_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [FCW_W-1:0]   cfg_start,
    input  logic [FCW_W-1:0]   cfg_stop,
    input  logic [FCW_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               go,
    input  logic               abort,
    output logic [FCW_W-1:0]   fcw_out,
    output logic               fcw_upd,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    sweep_state_t       state_q, state_d, phase;
    logic               dir_q, dir_d;
    logic [FCW_W-1:0]   fcw_q, fcw_d, nxt;
    logic               upd_q, upd_d, done_q, done_d, err_q, err_d;
    logic [FCW_W-1:0]   start_q, stop_q, step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [1:0]         mode_q;
    logic               cfg_acc, cfg_ok, timer_load, expire;
    logic [FCW_W:0]     up_sum, dn_diff;
    logic [FCW_W-1:0]   up_nxt, dn_nxt;

    assign cfg_ready = (state_q == ST_IDLE);
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign cfg_ok    = (step_q != '0) && (stop_q >= start_q);

    // Clamped neighbours of the current point. The extra MSB catches a carry
    // out of the top of the FCW range (up) or a borrow below zero (down).
    assign up_sum  = {1'b0, fcw_q} + {1'b0, step_q};
    assign dn_diff = {1'b0, fcw_q} - {1'b0, step_q};
    assign up_nxt  = (up_sum[FCW_W] || up_sum[FCW_W-1:0] > stop_q) ? stop_q : up_sum[FCW_W-1:0];
    assign dn_nxt  = (dn_diff[FCW_W] || dn_diff[FCW_W-1:0] < start_q) ? start_q : dn_diff[FCW_W-1:0];

    dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .load_i  (timer_load),
        .en_i    (state_q == ST_RUN),
        .dwell_i (dwell_q),
        .expire_o(expire)
    );

    // STEP is decided in the same cycle the dwell expires, so it never
    // occupies a cycle of its own: the next point shows up right after expiry.
    assign phase = (state_q == ST_RUN && expire) ? ST_STEP : state_q;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        fcw_d      = fcw_q;
        upd_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        timer_load = 1'b0;
        nxt        = fcw_q;

        if (cfg_acc) err_d = 1'b0;

        case (phase)
            ST_IDLE: begin
                // go is judged against the config already held; a failed go
                // flags the error even if a new config lands in the same cycle.
                if (go && !abort) begin
                    if (cfg_ok) begin
                        state_d    = ST_RUN;
                        dir_d      = DIR_UP;
                        fcw_d      = start_q;
                        upd_d      = 1'b1;
                        timer_load = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) state_d = ST_IDLE;
            end
            ST_STEP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (dir_q == DIR_UP && fcw_q == stop_q &&
                             mode_q != MODE_REPEAT && mode_q != MODE_TRI) begin
                    // Single (and reserved) mode ends on the stop point.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    if (dir_q == DIR_UP && fcw_q == stop_q) begin
                        if (mode_q == MODE_REPEAT) begin
                            nxt = start_q;
                        end else begin
                            dir_d = DIR_DOWN;
                            nxt   = dn_nxt;
                        end
                    end else if (dir_q == DIR_DOWN && fcw_q == start_q) begin
                        dir_d = DIR_UP;
                        nxt   = up_nxt;
                    end else begin
                        nxt = (dir_q == DIR_UP) ? up_nxt : dn_nxt;
                    end
                    fcw_d      = nxt;
                    upd_d      = (nxt != fcw_q);
                    timer_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            fcw_q   <= '0;
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            fcw_q   <= fcw_d;
            upd_q   <= upd_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (cfg_acc) begin
                start_q <= cfg_start;
                stop_q  <= cfg_stop;
                step_q  <= cfg_step;
                dwell_q <= cfg_dwell;
                mode_q  <= cfg_mode;
            end
        end
    end

    assign fcw_out = fcw_q;
    assign fcw_upd = upd_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign cfg_err = err_q;

endmodule : dds_sweep_ctrl

// File: tb/tb_dds_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//   Self-checking bench for dds_sweep_ctrl. Expected output streams come from
//   a list-based sweep model: the sequence of points is built with plain
//   min/max arithmetic, then expanded to per-cycle outputs.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    localparam logic [63:0] MAXV = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, cfg_valid, go, abort;
    logic        cfg_ready, fcw_upd, busy, done, cfg_err;
    logic [63:0] cfg_start, cfg_stop, cfg_step, fcw_out;
    logic [23:0] cfg_dwell;
    logic [1:0]  cfg_mode;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] pts[$];
    logic [63:0] exp_fcw[$];
    logic [2:0]  exp_flg[$];  // {upd, busy, done}

    dds_sweep_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_start(cfg_start),
        .cfg_stop (cfg_stop),
        .cfg_step (cfg_step),
        .cfg_dwell(cfg_dwell),
        .cfg_mode (cfg_mode),
        .go       (go),
        .abort    (abort),
        .fcw_out  (fcw_out),
        .fcw_upd  (fcw_upd),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // min(x + step, stop) and max(x - step, start) in unbounded arithmetic.
    function automatic logic [63:0] up_once(input logic [63:0] x, e, st);
        logic [64:0] sum;
        sum = {1'b0, x} + {1'b0, st};
        return (sum > {1'b0, e}) ? e : sum[63:0];
    endfunction

    function automatic logic [63:0] dn_once(input logic [63:0] x, s, st);
        if ({1'b0, x} < {1'b0, s} + {1'b0, st}) return s;
        return x - st;
    endfunction

    task automatic build_points(input logic [63:0] s, e, st, input logic [1:0] md, input int min_pts);
        logic [63:0] lst[$];
        logic [63:0] v;
        pts.delete();
        lst.push_back(s);
        v = s;
        while (v != e) begin
            v = up_once(v, e, st);
            lst.push_back(v);
        end
        pts = lst;
        if (md == 2'd1) begin
            while (pts.size() < min_pts) pts = {pts, lst};
        end else if (md == 2'd2) begin
            while (pts.size() < min_pts) begin
                v = e;
                do begin v = dn_once(v, s, st); pts.push_back(v); end while (v != s);
                do begin v = up_once(v, e, st); pts.push_back(v); end while (v != e);
            end
        end
    endtask

    task automatic expand(input logic [63:0] e, input logic [23:0] dw, input logic [1:0] md, input int ncyc);
        int hold;
        hold = (dw == 0) ? 1 : int'(dw);
        exp_fcw.delete();
        exp_flg.delete();
        foreach (pts[i]) begin
            for (int c = 0; c < hold; c++) begin
                exp_fcw.push_back(pts[i]);
                exp_flg.push_back({(c == 0) && (i == 0 || pts[i] != pts[i-1]), 1'b1, 1'b0});
            end
        end
        if (md == 2'd1 || md == 2'd2) begin
            while (exp_fcw.size() > ncyc) begin
                void'(exp_fcw.pop_back());
                void'(exp_flg.pop_back());
            end
        end else begin
            exp_fcw.push_back(e); exp_flg.push_back(3'b001);  // done, back in IDLE
            exp_fcw.push_back(e); exp_flg.push_back(3'b000);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic write_cfg(input logic [63:0] s, e, st, input logic [23:0] dw, input logic [1:0] md);
        cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw; cfg_mode = md;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [63:0] s, e, st,
                                 input logic [23:0] dw, input logic [1:0] md, input int ncyc);
        logic cont;
        int   n;
        cont = (md == 2'd1 || md == 2'd2);
        build_points(s, e, st, md, ncyc);
        expand(e, dw, md, ncyc);
        n = exp_fcw.size();
        write_cfg(s, e, st, dw, md);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int k = 0; k < n; k++) begin
            vectors++;
            if ({fcw_out, fcw_upd, busy, done} !== {exp_fcw[k], exp_flg[k]}) begin
                miscompares++;
                $display("FAIL %s[%0d]: got fcw=%h upd=%b busy=%b done=%b, want fcw=%h upd/busy/done=%b",
                         name, k, fcw_out, fcw_upd, busy, done, exp_fcw[k], exp_flg[k]);
            end
            if (cont && k == n - 1) abort = 1'b1;
            @(negedge clk);
        end
        if (cont) begin
            abort = 1'b0;
            vectors++;
            if ({fcw_out, fcw_upd, busy, done} !== {exp_fcw[n-1], 3'b000}) begin
                miscompares++;
                $display("FAIL %s_abort: got fcw=%h upd=%b busy=%b done=%b, want fcw=%h idle",
                         name, fcw_out, fcw_upd, busy, done, exp_fcw[n-1]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({fcw_out, fcw_upd, busy, done, cfg_err, cfg_ready} !== {64'd0, 5'b00001}) begin
            miscompares++;
            $display("FAIL reset: got fcw=%h upd=%b busy=%b done=%b err=%b rdy=%b, want 0/0/0/0/0/1",
                     fcw_out, fcw_upd, busy, done, cfg_err, cfg_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        run_and_check("single", 64'd100, 64'd130, 64'd10, 24'd4, 2'd0, 0);
        run_and_check("single_eq", 64'd77, 64'd77, 64'd3, 24'd2, 2'd0, 0);
        run_and_check("reserved_mode", 64'd5, 64'd9, 64'd2, 24'd1, 2'd3, 0);
    endtask

    task automatic test_clamp();
        run_and_check("clamp", 64'd100, 64'd125, 64'd10, 24'd2, 2'd0, 0);
        run_and_check("clamp_top", MAXV - 64'd4, MAXV, 64'd8, 24'd2, 2'd0, 0);
    endtask

    task automatic test_triangle();
        run_and_check("triangle", 64'd0, 64'd20, 64'd10, 24'd1, 2'd2, 12);
        run_and_check("tri_clamp", 64'd3, 64'd25, 64'd10, 24'd2, 2'd2, 30);
        run_and_check("tri_eq", 64'd50, 64'd50, 64'd10, 24'd1, 2'd2, 6);
        run_and_check("repeat", 64'd0, 64'd20, 64'd10, 24'd1, 2'd1, 12);
        run_and_check("repeat_eq", 64'd9, 64'd9, 64'd1, 24'd2, 2'd1, 8);
    endtask

    task automatic test_abort();
        write_cfg(64'd100, 64'd130, 64'd10, 24'd4, 2'd0);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);   // sixth cycle of the sweep: second point
        vectors++;
        if (fcw_out !== 64'd110) begin
            miscompares++;
            $display("FAIL abort_pre: got fcw=%0d, want 110", fcw_out);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if ({fcw_out, fcw_upd, busy, done, cfg_ready} !== {64'd110, 4'b0001}) begin
            miscompares++;
            $display("FAIL abort: got fcw=%0d upd=%b busy=%b done=%b rdy=%b, want 110 idle",
                     fcw_out, fcw_upd, busy, done, cfg_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if ({fcw_out, busy, done} !== {64'd110, 2'b00}) begin
                miscompares++;
                $display("FAIL abort_hold[%0d]: got fcw=%0d busy=%b done=%b, want 110/0/0",
                         i, fcw_out, busy, done);
            end
        end
        go = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        go = 1'b0;
        abort = 1'b0;
        vectors++;
        if ({fcw_out, fcw_upd, busy, cfg_err} !== {64'd110, 3'b000}) begin
            miscompares++;
            $display("FAIL abort_go: got fcw=%0d upd=%b busy=%b err=%b, want 110/0/0/0",
                     fcw_out, fcw_upd, busy, cfg_err);
        end
    endtask

    task automatic test_invalid();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // Reset leaves step=0, so the first go must be refused.
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        vectors++;
        if ({cfg_err, busy, fcw_out} !== {2'b10, 64'd0}) begin
            miscompares++;
            $display("FAIL inv_reset_cfg: got err=%b busy=%b fcw=%0d, want 1/0/0", cfg_err, busy, fcw_out);
        end
        write_cfg(64'd100, 64'd200, 64'd0, 24'd2, 2'd0);
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL inv_clear1: got err=%b, want 0", cfg_err);
        end
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        vectors++;
        if ({cfg_err, busy, fcw_out} !== {2'b10, 64'd0}) begin
            miscompares++;
            $display("FAIL inv_step0: got err=%b busy=%b fcw=%0d, want 1/0/0", cfg_err, busy, fcw_out);
        end
        write_cfg(64'd300, 64'd200, 64'd5, 24'd2, 2'd0);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        vectors++;
        if ({cfg_err, busy, fcw_out} !== {2'b10, 64'd0}) begin
            miscompares++;
            $display("FAIL inv_order: got err=%b busy=%b fcw=%0d, want 1/0/0", cfg_err, busy, fcw_out);
        end
        write_cfg(64'd200, 64'd300, 64'd50, 24'd1, 2'd0);
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL inv_clear2: got err=%b, want 0", cfg_err);
        end
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        vectors++;
        if ({cfg_err, busy, fcw_out} !== {2'b01, 64'd200}) begin
            miscompares++;
            $display("FAIL inv_then_valid: got err=%b busy=%b fcw=%0d, want 0/1/200", cfg_err, busy, fcw_out);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if ({busy, fcw_out} !== {1'b0, 64'd300}) begin
            miscompares++;
            $display("FAIL inv_valid_end: got busy=%b fcw=%0d, want 0/300", busy, fcw_out);
        end
    endtask

    task automatic test_dwell_busy_rst();
        run_and_check("dwell0_single", 64'd5, 64'd25, 64'd5, 24'd0, 2'd0, 0);
        run_and_check("dwell0_repeat", 64'd5, 64'd25, 64'd5, 24'd0, 2'd1, 12);
        write_cfg(64'd1000, 64'd1003, 64'd1, 24'd2, 2'd1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(negedge clk);
        cfg_start = 64'd7; cfg_stop = 64'd9; cfg_step = 64'd1; cfg_dwell = 24'd1; cfg_mode = 2'd0;
        cfg_valid = 1'b1;
        vectors++;
        if ({cfg_ready, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL busy_ready: got rdy=%b busy=%b, want 0/1", cfg_ready, busy);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        vectors++;
        if (fcw_out !== 64'd1001) begin
            miscompares++;
            $display("FAIL busy_cfg_run: got fcw=%0d, want 1001", fcw_out);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        vectors++;
        if ({fcw_out, fcw_upd} !== {64'd1000, 1'b1}) begin
            miscompares++;
            $display("FAIL busy_cfg_kept0: got fcw=%0d upd=%b, want 1000/1", fcw_out, fcw_upd);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if ({fcw_out, fcw_upd} !== {64'd1001, 1'b1}) begin
            miscompares++;
            $display("FAIL busy_cfg_kept1: got fcw=%0d upd=%b, want 1001/1", fcw_out, fcw_upd);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({fcw_out, fcw_upd, busy, done, cfg_err, cfg_ready} !== {64'd0, 5'b00001}) begin
            miscompares++;
            $display("FAIL rst_mid: got fcw=%0d upd=%b busy=%b done=%b err=%b rdy=%b, want reset values",
                     fcw_out, fcw_upd, busy, done, cfg_err, cfg_ready);
        end
    endtask

    task automatic test_random();
        logic [63:0] s, e, st, span;
        logic [23:0] dw;
        logic [1:0]  md;
        for (int it = 0; it < 25; it++) begin
            span = 64'($urandom_range(0, 200));
            st   = 64'($urandom_range(1, 60));
            dw   = 24'($urandom_range(0, 3));
            md   = 2'($urandom_range(0, 3));
            s    = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0 || s > MAXV - span) s = MAXV - span;
            e    = s + span;
            run_and_check($sformatf("rand%0d", it), s, e, st, dw, md, 40);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; go = 1'b0; abort = 1'b0;
        cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_clamp();
        test_triangle();
        test_abort();
        test_invalid();
        test_dwell_busy_rst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dds_sweep_ctrl
